// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StWait,
    StGap
  } rd_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; the pointer advances only when the grant is accepted.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // prio_q == 0 favours source 0 on a tie
  logic prio_q;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART TX scheduler: arbitrates two byte sources into the TX FIFO and paces
// FIFO pops into the shifter using the baud tick and an inter-frame gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_clk,
  input  logic                       s0_valid,
  input  logic [DATA_W-1:0]          s0_data,
  output logic                       s0_ready,
  input  logic                       s1_valid,
  input  logic [DATA_W-1:0]          s1_data,
  output logic                       s1_ready,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  input  logic                       fifo_full,
  output logic                       fifo_rd_en,
  input  logic [DATA_W-1:0]          fifo_rd_data,
  input  logic                       fifo_empty,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sched_idle
);

  localparam int unsigned LevelW = $clog2(DEPTH) + 1;
  localparam int unsigned GapW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [LevelW-1:0] LevelMax = LevelW'(DEPTH);

  logic [1:0]      grant;
  rd_state_e       state_q;
  logic [GapW-1:0] gap_q;
  logic            seen_busy_q;

  uart_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({s1_valid, s0_valid}),
    .accept (fifo_wr_en),
    .grant  (grant)
  );

  assign s0_ready     = grant[0] & ~fifo_full & ~rst;
  assign s1_ready     = grant[1] & ~fifo_full & ~rst;
  assign fifo_wr_en   = s0_ready | s1_ready;
  assign fifo_wr_data = grant[1] ? s1_data : s0_data;
  assign sched_idle   = (state_q == StIdle) && (level == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fifo_rd_en  <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      gap_q       <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_clk && !fifo_empty && !tx_busy) begin
            state_q    <= StPop;
            fifo_rd_en <= 1'b1;
          end
        end
        StPop: state_q <= StLoad;
        StLoad: begin
          tx_data  <= fifo_rd_data;
          tx_start <= 1'b1;
          state_q  <= StStart;
        end
        StStart: begin
          seen_busy_q <= 1'b0;
          state_q     <= StWait;
        end
        StWait: begin
          // The shifter may raise busy a cycle late, so wait for a full high-then-low
          if (tx_busy) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            if (GAP_TICKS == 0) begin
              state_q <= StIdle;
            end else begin
              gap_q   <= '0;
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (enable_clk) begin
            if (gap_q == GapLast) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (fifo_wr_en && !fifo_rd_en && level != LevelMax) begin
      level <= level + 1'b1;
    end else if (fifo_rd_en && !fifo_wr_en && level != '0) begin
      level <= level - 1'b1;
    end
  end

endmodule
